// File: rtl/wt_cache_pkg.sv
// Shared cache types for the write-through dcache: transaction id width, miss
// request payload and the arbiter FSM encoding.
package wt_cache_pkg;

  localparam int unsigned PLEN             = 56;
  localparam int unsigned CACHE_ID_WIDTH   = 3;
  localparam int unsigned DCACHE_SET_ASSOC = 4;
  localparam int unsigned DCS_WIDTH        = 4;

  typedef logic [DCS_WIDTH-1:0] dcs_data_t;

  typedef struct packed {
    logic                        we;
    logic [63:0]                 wdata;
    logic [DCACHE_SET_ASSOC-1:0] vld_bits;
    logic [PLEN-1:0]             paddr;
    logic                        nc;
    logic [2:0]                  size;
    logic [CACHE_ID_WIDTH-1:0]   id;
    dcs_data_t                   dcs;
  } miss_req_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wt_rr_arb_sel.sv
// Round-robin pick: index of the first set request bit at or after ptr_i,
// wrapping from NumPorts-1 back to 0. Purely combinational.
module wt_rr_arb_sel #(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned IdxW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic [NumPorts-1:0] req_i,
  input  logic [IdxW-1:0]     ptr_i,
  output logic [IdxW-1:0]     idx_o,
  output logic                vld_o
);

  int cand;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    idx_o = '0;
    vld_o = 1'b0;
    cand  = 0;
    // Scan from the farthest candidate down so the closest one to ptr_i wins.
    for (int k = int'(NumPorts) - 1; k >= 0; k--) begin
      cand = int'(ptr_i) + k;
      if (cand >= int'(NumPorts)) cand = cand - int'(NumPorts);
      if (req_i[cand]) begin
        idx_o = IdxW'(cand);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wt_dcache_miss_arb.sv
// Arbitrates the dcache read-port miss channels onto the single miss-unit
// request channel and steers ack/replay/return pulses back to the owner.
module wt_dcache_miss_arb
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumPorts   = 3,
  parameter int unsigned RdTxIdBase = 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NumPorts-1:0]                       port_req_i,
  output logic [NumPorts-1:0]                       port_ack_o,
  output logic [NumPorts-1:0]                       port_replay_o,
  output logic [NumPorts-1:0]                       port_rtrn_vld_o,
  input  logic [NumPorts-1:0]                       port_we_i,
  input  logic [NumPorts-1:0][63:0]                 port_wdata_i,
  input  logic [NumPorts-1:0][DCACHE_SET_ASSOC-1:0] port_vld_bits_i,
  input  logic [NumPorts-1:0][PLEN-1:0]             port_paddr_i,
  input  logic [NumPorts-1:0]                       port_nc_i,
  input  logic [NumPorts-1:0][2:0]                  port_size_i,
  input  logic [NumPorts-1:0][CACHE_ID_WIDTH-1:0]   port_id_i,
  input  logic [NumPorts-1:0][DCS_WIDTH-1:0]        port_dcs_i,
  output logic                                      miss_req_o,
  input  logic                                      miss_ack_i,
  input  logic                                      miss_replay_i,
  output logic                                      miss_we_o,
  output logic [63:0]                               miss_wdata_o,
  output logic [DCACHE_SET_ASSOC-1:0]               miss_vld_bits_o,
  output logic [PLEN-1:0]                           miss_paddr_o,
  output logic                                      miss_nc_o,
  output logic [2:0]                                miss_size_o,
  output logic [CACHE_ID_WIDTH-1:0]                 miss_id_o,
  output logic [DCS_WIDTH-1:0]                      miss_dcs_o,
  input  logic                                      miss_rtrn_vld_i,
  input  logic [CACHE_ID_WIDTH-1:0]                 miss_rtrn_id_i
);

  localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  arb_state_e                state_q;
  logic      [IdxW-1:0]      rr_ptr_q;
  logic      [IdxW-1:0]      winner_q;
  logic      [IdxW-1:0]      next_ptr;
  logic      [IdxW-1:0]      sel_idx;
  logic                      sel_vld;
  miss_req_t                 req_q;
  miss_req_t [NumPorts-1:0]  port_data;

  always_comb begin
    for (int i = 0; i < int'(NumPorts); i++) begin
      port_data[i] = '{we:       port_we_i[i],
                       wdata:    port_wdata_i[i],
                       vld_bits: port_vld_bits_i[i],
                       paddr:    port_paddr_i[i],
                       nc:       port_nc_i[i],
                       size:     port_size_i[i],
                       id:       port_id_i[i],
                       dcs:      port_dcs_i[i]};
    end
  end

  wt_rr_arb_sel #(
    .NumPorts(NumPorts),
    .IdxW    (IdxW)
  ) i_rr_sel (
    .req_i(port_req_i),
    .ptr_i(rr_ptr_q),
    .idx_o(sel_idx),
    .vld_o(sel_vld)
  );

  // Explicit wrap so non-power-of-two port counts rotate correctly.
  assign next_ptr = (winner_q == IdxW'(NumPorts - 1)) ? '0 : winner_q + IdxW'(1);

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      winner_q   <= '0;
      req_q      <= '0;
      miss_req_o <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (sel_vld) begin
            winner_q   <= sel_idx;
            req_q      <= port_data[sel_idx];
            miss_req_o <= 1'b1;
            state_q    <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          if (miss_ack_i || miss_replay_i) begin
            rr_ptr_q   <= next_ptr;
            miss_req_o <= 1'b0;
            state_q    <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Replay wins over a simultaneous ack; nothing is forwarded while in reset.
  always_comb begin
    port_ack_o    = '0;
    port_replay_o = '0;
    if (rst_ni && state_q == ARB_LOCK) begin
      if (miss_replay_i)   port_replay_o[winner_q] = 1'b1;
      else if (miss_ack_i) port_ack_o[winner_q]    = 1'b1;
    end
  end

  // Ids outside this block's range belong to other requesters and are ignored.
  always_comb begin
    for (int i = 0; i < int'(NumPorts); i++) begin
      port_rtrn_vld_o[i] = miss_rtrn_vld_i &&
                           (miss_rtrn_id_i == CACHE_ID_WIDTH'(RdTxIdBase + i));
    end
  end

  assign miss_we_o       = req_q.we;
  assign miss_wdata_o    = req_q.wdata;
  assign miss_vld_bits_o = req_q.vld_bits;
  assign miss_paddr_o    = req_q.paddr;
  assign miss_nc_o       = req_q.nc;
  assign miss_size_o     = req_q.size;
  assign miss_id_o       = req_q.id;
  assign miss_dcs_o      = req_q.dcs;

`ifndef SYNTHESIS
  for (genvar i = 0; i < NumPorts; i++) begin : g_id_chk
    a_port_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
      port_req_i[i] |-> port_id_i[i] == CACHE_ID_WIDTH'(RdTxIdBase + i));
  end

  a_onehot_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(port_ack_o | port_replay_o));

  a_resp_with_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (miss_ack_i || miss_replay_i) |-> miss_req_o);

  a_no_withdraw: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == ARB_LOCK) |-> port_req_i[winner_q]);
`endif

endmodule

// File: tb/tb_wt_dcache_miss_arb.sv
// Scoreboard bench for wt_dcache_miss_arb: expected grants and ack/replay
// pulses are queued by the stimulus and popped by an independent monitor.
module tb_wt_dcache_miss_arb;
  import wt_cache_pkg::*;

  localparam int NP   = 3;
  localparam int BASE = 1;

  logic                                clk_i  = 1'b0;
  logic                                rst_ni = 1'b0;
  logic [NP-1:0]                       port_req_i;
  logic [NP-1:0]                       port_ack_o, port_replay_o, port_rtrn_vld_o;
  logic [NP-1:0]                       port_we_i;
  logic [NP-1:0][63:0]                 port_wdata_i;
  logic [NP-1:0][DCACHE_SET_ASSOC-1:0] port_vld_bits_i;
  logic [NP-1:0][PLEN-1:0]             port_paddr_i;
  logic [NP-1:0]                       port_nc_i;
  logic [NP-1:0][2:0]                  port_size_i;
  logic [NP-1:0][CACHE_ID_WIDTH-1:0]   port_id_i;
  logic [NP-1:0][DCS_WIDTH-1:0]        port_dcs_i;
  logic                                miss_req_o, miss_ack_i, miss_replay_i;
  logic                                miss_we_o, miss_nc_o;
  logic [63:0]                         miss_wdata_o;
  logic [DCACHE_SET_ASSOC-1:0]         miss_vld_bits_o;
  logic [PLEN-1:0]                     miss_paddr_o;
  logic [2:0]                          miss_size_o;
  logic [CACHE_ID_WIDTH-1:0]           miss_id_o;
  logic [DCS_WIDTH-1:0]                miss_dcs_o;
  logic                                miss_rtrn_vld_i;
  logic [CACHE_ID_WIDTH-1:0]           miss_rtrn_id_i;

  wt_dcache_miss_arb #(.NumPorts(NP), .RdTxIdBase(BASE)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .port_req_i(port_req_i), .port_ack_o(port_ack_o), .port_replay_o(port_replay_o),
    .port_rtrn_vld_o(port_rtrn_vld_o), .port_we_i(port_we_i), .port_wdata_i(port_wdata_i),
    .port_vld_bits_i(port_vld_bits_i), .port_paddr_i(port_paddr_i), .port_nc_i(port_nc_i),
    .port_size_i(port_size_i), .port_id_i(port_id_i), .port_dcs_i(port_dcs_i),
    .miss_req_o(miss_req_o), .miss_ack_i(miss_ack_i), .miss_replay_i(miss_replay_i),
    .miss_we_o(miss_we_o), .miss_wdata_o(miss_wdata_o), .miss_vld_bits_o(miss_vld_bits_o),
    .miss_paddr_o(miss_paddr_o), .miss_nc_o(miss_nc_o), .miss_size_o(miss_size_o),
    .miss_id_o(miss_id_o), .miss_dcs_o(miss_dcs_o),
    .miss_rtrn_vld_i(miss_rtrn_vld_i), .miss_rtrn_id_i(miss_rtrn_id_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [PLEN-1:0] paddr;
    logic [2:0]      id;
    logic [2:0]      size;
    logic [63:0]     wdata;
  } grant_t;

  grant_t      grant_q[$];
  logic [5:0]  resp_q[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_port(input int p, input logic [63:0] paddr, input logic [2:0] size,
                          input logic [63:0] wdata);
    port_paddr_i[p] = PLEN'(paddr);
    port_size_i[p]  = size;
    port_wdata_i[p] = wdata;
  endtask

  task automatic push_grant(input int p);
    grant_t g;
    g.paddr = port_paddr_i[p];
    g.id    = 3'(BASE + p);
    g.size  = port_size_i[p];
    g.wdata = port_wdata_i[p];
    grant_q.push_back(g);
  endtask

  task automatic wait_req();
    int n = 0;
    while (miss_req_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_timeout", 64'(miss_req_o), 64'd1);
  endtask

  // Waits for the lock, then answers it for one cycle and optionally drops the port.
  task automatic serve(input int p, input bit ack, input bit rep, input bit drop);
    logic [NP-1:0] a, r;
    wait_req();
    a = '0;
    r = '0;
    if (rep)      r[p] = 1'b1;
    else if (ack) a[p] = 1'b1;
    resp_q.push_back({a, r});
    miss_ack_i    = ack;
    miss_replay_i = rep;
    tick();
    miss_ack_i    = 1'b0;
    miss_replay_i = 1'b0;
    if (drop) port_req_i[p] = 1'b0;
  endtask

  task automatic check_zero_payload(input string tag);
    check({tag, "_req"},   64'(miss_req_o), 64'd0);
    check({tag, "_paddr"}, 64'(miss_paddr_o), 64'd0);
    check({tag, "_wdata"}, miss_wdata_o, 64'd0);
    check({tag, "_misc"},  64'({miss_we_o, miss_nc_o, miss_size_o, miss_id_o,
                                miss_vld_bits_o, miss_dcs_o}), 64'd0);
  endtask

  // Monitor: a new grant is a rising miss_req_o; any ack/replay pulse pops a response.
  logic   prev_req = 1'b0;
  grant_t mon_g;
  logic [5:0] mon_r;
  always @(negedge clk_i) begin
    if (miss_req_o === 1'b1 && prev_req !== 1'b1) begin
      if (grant_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant: got id %0d expected no grant", miss_id_o);
      end else begin
        mon_g = grant_q.pop_front();
        check("grant_id",    64'(miss_id_o), 64'(mon_g.id));
        check("grant_paddr", 64'(miss_paddr_o), 64'(mon_g.paddr));
        check("grant_size",  64'(miss_size_o), 64'(mon_g.size));
        check("grant_wdata", miss_wdata_o, mon_g.wdata);
      end
    end
    prev_req = miss_req_o;
    if ((port_ack_o | port_replay_o) != '0) begin
      if (resp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got ack=%b replay=%b expected none", port_ack_o, port_replay_o);
      end else begin
        mon_r = resp_q.pop_front();
        check("resp_ack_replay", 64'({port_ack_o, port_replay_o}), 64'(mon_r));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    port_req_i      = '0;
    miss_ack_i      = 1'b0;
    miss_replay_i   = 1'b0;
    miss_rtrn_vld_i = 1'b0;
    miss_rtrn_id_i  = '0;
    for (int p = 0; p < NP; p++) begin
      port_id_i[p]       = 3'(BASE + p);
      port_we_i[p]       = p[0];
      port_nc_i[p]       = (p == 2);
      port_vld_bits_i[p] = 4'(p + 5);
      port_dcs_i[p]      = 4'(p + 9);
      set_port(p, 64'h8000_0000 + 64'(p) * 64'h100, 3'd3, 64'hA000 + 64'(p));
    end

    // Reset state
    tick();
    tick();
    check_zero_payload("reset");
    check("reset_ack", 64'({port_ack_o, port_replay_o}), 64'd0);
    rst_ni = 1'b1;

    // Single request from port 1: one-cycle latency, held payload, ack to port 1 only
    tick();
    set_port(1, 64'h8000_1040, 3'b111, 64'hDEAD_BEEF);
    port_req_i[1] = 1'b1;
    push_grant(1);
    check("t1_req_before", 64'(miss_req_o), 64'd0);
    tick();
    check("t1_req_after", 64'(miss_req_o), 64'd1);
    check("t1_id", 64'(miss_id_o), 64'd2);
    tick();
    check("t1_paddr_held", 64'(miss_paddr_o), 64'h8000_1040);
    serve(1, 1'b1, 1'b0, 1'b1);
    check("t1_req_dropped", 64'(miss_req_o), 64'd0);

    // Port 2 alone: rr_ptr wraps back to 0
    set_port(2, 64'h8000_2200, 3'd2, 64'h2222);
    port_req_i[2] = 1'b1;
    push_grant(2);
    serve(2, 1'b1, 1'b0, 1'b1);

    // All three at once from rr_ptr=0: 0,1,2; then 0 and 2 again: 0,2
    for (int p = 0; p < NP; p++) begin
      set_port(p, 64'h9000_0000 + 64'(p) * 64'h40, 3'(p), 64'h3000 + 64'(p));
      port_req_i[p] = 1'b1;
      push_grant(p);
    end
    for (int p = 0; p < NP; p++) serve(p, 1'b1, 1'b0, 1'b1);
    set_port(0, 64'h9100_0000, 3'd1, 64'h4000);
    set_port(2, 64'h9100_0080, 3'd3, 64'h4002);
    port_req_i[0] = 1'b1;
    port_req_i[2] = 1'b1;
    push_grant(0);
    push_grant(2);
    serve(0, 1'b1, 1'b0, 1'b1);
    serve(2, 1'b1, 1'b0, 1'b1);

    // Replay on port 0 while port 1 waits: port 1 goes first, then port 0 again
    set_port(0, 64'hA000_0000, 3'd3, 64'h5000);
    port_req_i[0] = 1'b1;
    push_grant(0);
    wait_req();
    set_port(1, 64'hA000_0100, 3'd2, 64'h5001);
    port_req_i[1] = 1'b1;
    push_grant(1);
    push_grant(0);
    serve(0, 1'b0, 1'b1, 1'b0);
    serve(1, 1'b1, 1'b0, 1'b1);
    serve(0, 1'b1, 1'b0, 1'b1);

    // Ack and replay together on port 2: only the replay is forwarded
    set_port(2, 64'hB000_0000, 3'd0, 64'h6002);
    port_req_i[2] = 1'b1;
    push_grant(2);
    serve(2, 1'b1, 1'b1, 1'b1);

    // Return path while port 0 is locked
    set_port(0, 64'hC000_0000, 3'd3, 64'h7000);
    port_req_i[0] = 1'b1;
    push_grant(0);
    wait_req();
    miss_rtrn_vld_i = 1'b1;
    miss_rtrn_id_i  = 3'd3;
    #2 check("rtrn_id3", 64'(port_rtrn_vld_o), 64'b100);
    miss_rtrn_id_i  = 3'd7;
    #2 check("rtrn_id7", 64'(port_rtrn_vld_o), 64'b000);
    miss_rtrn_id_i  = 3'd1;
    #2 check("rtrn_id1", 64'(port_rtrn_vld_o), 64'b001);
    tick();
    miss_rtrn_vld_i = 1'b0;
    #1 check("rtrn_vld_low", 64'(port_rtrn_vld_o), 64'b000);
    check("rtrn_lock_kept", 64'(miss_req_o), 64'd1);
    check("rtrn_paddr_kept", 64'(miss_paddr_o), 64'hC000_0000);
    serve(0, 1'b1, 1'b0, 1'b1);

    // Reset mid-lock on port 1 (rr_ptr=1): request dropped, restart from port 0
    set_port(1, 64'hD000_0100, 3'd3, 64'h8001);
    port_req_i[1] = 1'b1;
    push_grant(1);
    wait_req();
    set_port(0, 64'hD000_0000, 3'd2, 64'h8000);
    port_req_i[0] = 1'b1;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check_zero_payload("midlock_rst");
    push_grant(0);
    push_grant(1);
    serve(0, 1'b1, 1'b0, 1'b1);
    serve(1, 1'b1, 1'b0, 1'b1);

    tick();
    tick();
    check("grant_q_drained", 64'(grant_q.size()), 64'd0);
    check("resp_q_drained", 64'(resp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wt_dcache_miss_arb.md
Name: wt_dcache_miss_arb

Overview:
- Arbitrates the miss-request channels of NumPorts dcache read-port controllers onto the single request channel of the dcache miss unit.
- Registers the winning request and holds it stable until the miss unit acks or replays it.
- Routes ack, replay and miss-return-valid pulses back to the owning port.
- Sits between the read-port controllers (upstream) and the miss unit (downstream).

Parameters:
- NumPorts, 3, number of read-port controllers arbitrated.
- RdTxIdBase, 1, CACHE_ID of port 0; port i is fixed to id RdTxIdBase+i.

Ports:
Clock and reset: one clock; reset is synchronous and active-low (clk_i, rst_ni).
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- port_req_i  in  NumPorts  per-port miss request
- port_ack_o  out  NumPorts  per-port miss ack
- port_replay_o  out  NumPorts  per-port replay
- port_rtrn_vld_o  out  NumPorts  per-port miss served
- port_we_i, port_wdata_i  in  NumPorts x 1, NumPorts x 64  per-port write flag and write data
- port_vld_bits_i  in  NumPorts x DCACHE_SET_ASSOC  valid bits at the missed index
- port_paddr_i  in  NumPorts x riscv::PLEN  physical address
- port_nc_i  in  NumPorts  noncacheable flag
- port_size_i  in  NumPorts x 3  access size
- port_id_i  in  NumPorts x CACHE_ID_WIDTH  transaction id
- port_dcs_i  in  NumPorts x dcs_data_t  DCS data
- miss_req_o  out  1  request to miss unit
- miss_ack_i, miss_replay_i  in  1  request accepted / must be replayed
- miss_we_o, miss_wdata_o, miss_vld_bits_o, miss_paddr_o, miss_nc_o, miss_size_o, miss_id_o, miss_dcs_o  out  same widths  registered winner fields
- miss_rtrn_vld_i  in  1  miss served
- miss_rtrn_id_i  in  CACHE_ID_WIDTH  id of served miss

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): state=IDLE, rr_ptr=0, winner=0, all registered payload fields 0, miss_req_o=0.
- Reset asserted mid-LOCK drops the outstanding request. No ack or replay is forwarded afterwards.
- FSM IDLE:
  - If any port_req_i is set, select the first requesting port at or after rr_ptr, scanning with wrap at NumPorts-1 to 0.
  - Capture that port's payload and its index into the winner register; next state LOCK.
  - miss_req_o=0 in IDLE, so request latency is 1 cycle from port_req_i to miss_req_o.
- FSM LOCK:
  - miss_req_o=1; payload outputs held constant.
  - miss_ack_i: port_ack_o[winner]=1 in the same cycle (combinational); rr_ptr=winner+1 mod NumPorts; next state IDLE.
  - miss_replay_i: port_replay_o[winner]=1 same cycle; rr_ptr update and next state as for ack.
  - ack and replay together: replay takes priority and ack is suppressed.
  - Neither: stay in LOCK.
- Non-winning ports never see ack or replay.
- Ports keep port_req_i high until they receive ack or replay, including while they are being killed. Withdrawal while locked is a protocol error, flagged by an assertion. The arbiter does not act on it.
- Minimum spacing between grants is 2 cycles. After ack or replay the arbiter returns to IDLE, and the acked port's request is already low in the next cycle.
- Return path, independent of the FSM: port_rtrn_vld_o[i] = miss_rtrn_vld_i && (miss_rtrn_id_i == RdTxIdBase+i).
  - Ids outside the port range produce no output; they belong to other requesters such as the write buffer.
  - The return path is active in every state, including the same cycle as an ack.
- Assertions:
  - port_id_i[i] == RdTxIdBase+i whenever port_req_i[i] is set.
  - $onehot0(port_ack_o | port_replay_o).
  - miss_ack_i and miss_replay_i are only asserted while miss_req_o=1.
- Arithmetic: rr_ptr and winner are $clog2(NumPorts) bits wide. Increment wraps explicitly at NumPorts-1; no reliance on power-of-2 overflow.

Decomposition:
- dcs_data_t, CACHE_ID_WIDTH, DCACHE_SET_ASSOC and a packed miss_req_t struct (we, wdata, vld_bits, paddr, nc, size, id, dcs) belong in wt_cache_pkg. The port arrays are declared as miss_req_t [NumPorts-1:0].
- One sub-module, wt_rr_arb_sel: combinational first-set-at-or-after-pointer selector that returns the index and a valid flag.

Test Plan:
- Single port 1 request, paddr=0x8000_1040, size=3'b111 -> miss_req_o=1 one cycle later with miss_paddr_o=0x8000_1040 and miss_id_o=2. Ack in cycle 3 -> port_ack_o=3'b010 that cycle; miss_req_o=0 in cycle 4.
- Ports 0, 1, 2 request simultaneously with rr_ptr=0, each acked and then deasserting -> grant order 0, 1, 2; then with ports 0 and 2 re-requesting -> order 0, 2.
- Port 0 locked, miss unit replays -> port_replay_o=3'b001 and no ack; rr_ptr=1; port 0 re-requests and wins only after port 1 if port 1 is pending.
- miss_ack_i and miss_replay_i in the same cycle -> only port_replay_o pulses.
- miss_rtrn_vld_i=1 with id 3 while LOCK on port 0 -> port_rtrn_vld_o=3'b100 and the lock is unaffected; id 7 -> port_rtrn_vld_o=0.
- rst_ni=0 for one cycle while LOCK -> next cycle miss_req_o=0, all payload outputs 0, no ack or replay forwarded; arbitration restarts from port 0.
